// File: rtl/sent_rx_frame_decoder_if.sv
// Decoded SENT fast-channel frame bundle.
// The decoder drives it through master; consumers read it through slave.
interface sent_rx_frame_decoder_if;
   logic [23:0] data_o;
   logic [3:0]  status_o;
   logic [3:0]  crc_o;
   logic        frame_valid_o;
   logic        crc_err_o;
   logic        pulse_err_o;

   modport master (
      output data_o, status_o, crc_o,
      output frame_valid_o, crc_err_o, pulse_err_o
   );

   modport slave (
      input data_o, status_o, crc_o,
      input frame_valid_o, crc_err_o, pulse_err_o
   );
endinterface

// File: rtl/sent_rx_frame_decoder.sv
// SENT receiver: measures fall-to-fall intervals in ticks and decodes frames.
// Optional pause-pulse state enabled by SENT_RX_PAUSE_EN.
module sent_rx_frame_decoder #(
   parameter int CLKS_PER_TICK = 3
) (
   input  logic clk_rx,
   input  logic reset_n_rx,
   input  logic data_pulse_i,
   sent_rx_frame_decoder_if.master rx
);

   localparam int PW = $clog2(CLKS_PER_TICK);
   localparam logic [3:0] CRC_SEED = 4'b0101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_STATUS,
      S_DATA,
`ifdef SENT_RX_PAUSE_EN
      S_PAUSE,
`endif
      S_CRC
   } state_t;

   function automatic logic [3:0] crc_nib(
      input logic [3:0] c,
      input logic [3:0] n
   );
      logic [3:0] r;
      logic       fb;
      r = c;
      for (int i = 3; i >= 0; i--) begin
         fb = r[3] ^ n[i];
         r  = {r[2:0], 1'b0} ^ (fb ? 4'hD : 4'h0);
      end
      return r;
   endfunction

   logic          s1, s2, s2_q;
   logic [PW-1:0] pre_q;
   logic [9:0]    tick_q;
   state_t        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [23:0]   dsh_q, dsh_d;
   logic [3:0]    ssh_q, ssh_d;
   logic [3:0]    crc_q, crc_d;
   logic [23:0]   data_q, data_d;
   logic [3:0]    stat_q, stat_d;
   logic [3:0]    crco_q, crco_d;
   logic          fv_q, fv_d, ce_q, ce_d, pe_q, pe_d;

   logic          edge_w, rnd_w, legal_w, sat_w;
   logic [10:0]   sum_w;
   logic [9:0]    ival_w;
   logic [3:0]    nib_w;

   assign edge_w  = s2_q & ~s2;
   assign rnd_w   = pre_q >= PW'(CLKS_PER_TICK / 2);
   assign sum_w   = {1'b0, tick_q} + {10'd0, rnd_w};
   assign ival_w  = sum_w[10] ? 10'd1023 : sum_w[9:0];
   assign legal_w = (ival_w >= 10'd12) && (ival_w <= 10'd27);
   assign nib_w   = ival_w[3:0] + 4'd4;
   assign sat_w   = tick_q == 10'd1023;

   always_ff @(posedge clk_rx) begin
      if (!reset_n_rx) begin
         s1     <= 1'b1;
         s2     <= 1'b1;
         s2_q   <= 1'b1;
         pre_q  <= '0;
         tick_q <= '0;
      end else begin
         s1   <= data_pulse_i;
         s2   <= s1;
         s2_q <= s2;
         if (edge_w) begin
            pre_q  <= '0;
            tick_q <= '0;
         end else if (pre_q == PW'(CLKS_PER_TICK - 1)) begin
            pre_q <= '0;
            if (!sat_w) tick_q <= tick_q + 10'd1;
         end else begin
            pre_q <= pre_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk_rx) begin
      if (!reset_n_rx) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         dsh_q   <= '0;
         ssh_q   <= '0;
         crc_q   <= '0;
         data_q  <= '0;
         stat_q  <= '0;
         crco_q  <= '0;
         fv_q    <= 1'b0;
         ce_q    <= 1'b0;
         pe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dsh_q   <= dsh_d;
         ssh_q   <= ssh_d;
         crc_q   <= crc_d;
         data_q  <= data_d;
         stat_q  <= stat_d;
         crco_q  <= crco_d;
         fv_q    <= fv_d;
         ce_q    <= ce_d;
         pe_q    <= pe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dsh_d   = dsh_q;
      ssh_d   = ssh_q;
      crc_d   = crc_q;
      data_d  = data_q;
      stat_d  = stat_q;
      crco_d  = crco_q;
      fv_d    = 1'b0;
      ce_d    = 1'b0;
      pe_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (edge_w) state_d = S_SYNC;
         end
         S_SYNC: begin
            if (edge_w && ival_w == 10'd56) begin
               state_d = S_STATUS;
               crc_d   = CRC_SEED;
            end
         end
         S_STATUS: begin
            if (edge_w && legal_w) begin
               ssh_d   = nib_w;
               idx_d   = '0;
               state_d = S_DATA;
            end else if (edge_w || sat_w) begin
               pe_d    = 1'b1;
               state_d = S_SYNC;
            end
         end
         S_DATA: begin
            if (edge_w && legal_w) begin
               dsh_d = {dsh_q[19:0], nib_w};
               crc_d = crc_nib(crc_q, nib_w);
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd5) state_d = S_CRC;
            end else if (edge_w || sat_w) begin
               pe_d    = 1'b1;
               state_d = S_SYNC;
            end
         end
         S_CRC: begin
            if (edge_w && legal_w) begin
               data_d  = dsh_q;
               stat_d  = ssh_q;
               crco_d  = nib_w;
               fv_d    = nib_w == crc_q;
               ce_d    = nib_w != crc_q;
`ifdef SENT_RX_PAUSE_EN
               state_d = S_PAUSE;
`else
               state_d = S_SYNC;
`endif
            end else if (edge_w || sat_w) begin
               pe_d    = 1'b1;
               state_d = S_SYNC;
            end
         end
`ifdef SENT_RX_PAUSE_EN
         // A 56-tick interval here means the transmitter skipped the pause
         S_PAUSE: begin
            if (edge_w && ival_w == 10'd56) begin
               state_d = S_STATUS;
               crc_d   = CRC_SEED;
            end else if (edge_w && ival_w >= 10'd12 && ival_w <= 10'd768) begin
               state_d = S_SYNC;
            end else if (edge_w || sat_w) begin
               pe_d    = 1'b1;
               state_d = S_SYNC;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   assign rx.data_o        = data_q;
   assign rx.status_o      = stat_q;
   assign rx.crc_o         = crco_q;
   assign rx.frame_valid_o = fv_q;
   assign rx.crc_err_o     = ce_q;
   assign rx.pulse_err_o   = pe_q;

endmodule
